// File: rtl/mem_access_ctrl_if.sv
// Request-side bus between the memory pipeline stage (master) and mem_access_ctrl (slave).
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic                  req;
   logic [2:0]            op;
   logic [ADDR_W-1:0]     addr;
   logic [2*DATA_W-1:0]   wdata;
   logic                  busy;
   logic                  done;
   logic [2*DATA_W-1:0]   rdata;
   logic [ADDR_W-1:0]     sp;
   logic                  stack_err;

   modport master (output req, op, addr, wdata,
                   input  busy, done, rdata, sp, stack_err);
   modport slave  (input  req, op, addr, wdata,
                   output busy, done, rdata, sp, stack_err);
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: load/store/push/pop plus two-word PC push/pop, owns the stack pointer.
// Optional stack bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module mem_access_ctrl #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int SP_INIT     = 2043,
   parameter int STACK_FLOOR = 1024
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_ctrl_if.slave  bus,
   output logic              mem_read_enable,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_read_addr,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_STORE = 3'd2;
   localparam logic [2:0] OP_PUSH  = 3'd3;
   localparam logic [2:0] OP_POP   = 3'd4;
   localparam logic [2:0] OP_PUSH2 = 3'd5;
   localparam logic [2:0] OP_POP2  = 3'd6;

   state_t                state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [2*DATA_W-1:0]   wdata_q, wdata_d;
   logic                  err_q, err_d;
   logic [ADDR_W-1:0]     sp_q, sp_d;
   logic [DATA_W-1:0]     lo_q, lo_d;
   logic [2*DATA_W-1:0]   rdata_q, rdata_d;
   logic                  done_q, done_d;
   logic                  stack_err_q, stack_err_d;

   logic              accept, two_word, last, chk_err;
   logic [ADDR_W-1:0] sp_p1, sp_p2, sp_m1, sp_m2;

   assign sp_p1    = sp_q + ADDR_W'(1);
   assign sp_p2    = sp_q + ADDR_W'(2);
   assign sp_m1    = sp_q - ADDR_W'(1);
   assign sp_m2    = sp_q - ADDR_W'(2);
   assign accept   = (state_q == IDLE) && bus.req;
   assign two_word = (op_q == OP_PUSH2) || (op_q == OP_POP2);
   assign last     = ((state_q == ACC1) && !two_word) || (state_q == ACC2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         sp_q        <= ADDR_W'(SP_INIT);
         lo_q        <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         stack_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         sp_q        <= sp_d;
         lo_q        <= lo_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         stack_err_q <= stack_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req) state_d = ACC1;
         ACC1:    state_d = two_word ? ACC2 : IDLE;
         ACC2:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bounds are judged once at accept against the pre-operation stack pointer.
   always_comb begin
      chk_err = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
      case (bus.op)
         OP_PUSH:  chk_err = sp_q  < ADDR_W'(STACK_FLOOR);
         OP_PUSH2: chk_err = sp_m1 < ADDR_W'(STACK_FLOOR);
         OP_POP:   chk_err = sp_p1 > ADDR_W'(SP_INIT);
         OP_POP2:  chk_err = sp_p2 > ADDR_W'(SP_INIT);
         default:  chk_err = 1'b0;
      endcase
`endif
   end

   always_comb begin
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      sp_d        = sp_q;
      lo_d        = lo_q;
      rdata_d     = rdata_q;
      done_d      = last;
      stack_err_d = last && err_q;
      if (accept) begin
         op_d    = bus.op;
         addr_d  = bus.addr;
         wdata_d = bus.wdata;
         err_d   = chk_err;
      end
      if ((state_q == ACC1) && (op_q == OP_POP2)) lo_d = mem_read_data;
      if (last) begin
         rdata_d = '0;
         if (!err_q) begin
            case (op_q)
               OP_LOAD:  rdata_d = {{DATA_W{1'b0}}, mem_read_data};
               OP_POP:   begin rdata_d = {{DATA_W{1'b0}}, mem_read_data}; sp_d = sp_p1; end
               OP_POP2:  begin rdata_d = {mem_read_data, lo_q}; sp_d = sp_p2; end
               OP_PUSH:  sp_d = sp_m1;
               OP_PUSH2: sp_d = sp_m2;
               default:  ;
            endcase
         end
      end
   end

   always_comb begin
      bus.busy         = (state_q != IDLE);
      bus.done         = done_q;
      bus.rdata        = rdata_q;
      bus.sp           = sp_q;
      bus.stack_err    = stack_err_q;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_read_addr    = '0;
      mem_write_addr   = '0;
      mem_write_data   = '0;
      if (!err_q && (state_q == ACC1)) begin
         case (op_q)
            OP_LOAD:  begin mem_read_enable = 1'b1; mem_read_addr = addr_q; end
            OP_STORE: begin mem_write_enable = 1'b1; mem_write_addr = addr_q;
                            mem_write_data = wdata_q[DATA_W-1:0]; end
            OP_PUSH:  begin mem_write_enable = 1'b1; mem_write_addr = sp_q;
                            mem_write_data = wdata_q[DATA_W-1:0]; end
            OP_PUSH2: begin mem_write_enable = 1'b1; mem_write_addr = sp_q;
                            mem_write_data = wdata_q[2*DATA_W-1:DATA_W]; end
            OP_POP,
            OP_POP2:  begin mem_read_enable = 1'b1; mem_read_addr = sp_p1; end
            default:  ;
         endcase
      end else if (!err_q && (state_q == ACC2)) begin
         if (op_q == OP_PUSH2) begin
            mem_write_enable = 1'b1;
            mem_write_addr   = sp_m1;
            mem_write_data   = wdata_q[DATA_W-1:0];
         end else if (op_q == OP_POP2) begin
            mem_read_enable = 1'b1;
            mem_read_addr   = sp_p2;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level stack/memory model.
module tb_mem_access_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_access_ctrl_if bus ();
   logic        mem_read_enable, mem_write_enable;
   logic [15:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

   mem_access_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_read_addr    (mem_read_addr),
      .mem_write_addr   (mem_write_addr),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   logic [15:0] dmem [0:65535];
   logic [15:0] rm   [0:65535];
   logic [15:0] ref_sp;
   assign mem_read_data = dmem[mem_read_addr];

   int total = 0, bad = 0, done_cnt = 0, exp_done = 0;
   logic both_seen = 1'b0;
   logic [15:0] wa_q[$], wd_q[$], ra_q[$];

   always @(negedge clk) begin
      if (mem_write_enable) begin
         wa_q.push_back(mem_write_addr);
         wd_q.push_back(mem_write_data);
         dmem[mem_write_addr] = mem_write_data;
      end
      if (mem_read_enable) ra_q.push_back(mem_read_addr);
      if (mem_read_enable && mem_write_enable) both_seen = 1'b1;
      if (bus.done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the controller idle; returns at the negedge where done is seen.
   task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [31:0] wd);
      logic [31:0] e_rd;
      logic        e_err;
      int          e_lat, n;
      logic [15:0] p, ewa[$], ewd[$], era[$];
      e_rd  = '0;
      e_err = 1'b0;
      e_lat = (op == 3'd5 || op == 3'd6) ? 3 : 2;
`ifdef STACK_BOUNDS_CHECK_EN
      case (op)
         3'd3: e_err = !(int'(ref_sp) >= 1024);
         3'd5: e_err = !(int'(ref_sp) - 1 >= 1024);
         3'd4: e_err = !(int'(ref_sp) + 1 <= 2043);
         3'd6: e_err = !(int'(ref_sp) + 2 <= 2043);
         default: e_err = 1'b0;
      endcase
`endif
      if (!e_err) begin
         case (op)
            3'd1: begin era.push_back(a); e_rd = {16'h0, rm[a]}; end
            3'd2: begin ewa.push_back(a); ewd.push_back(wd[15:0]); rm[a] = wd[15:0]; end
            3'd3: begin
               ewa.push_back(ref_sp); ewd.push_back(wd[15:0]); rm[ref_sp] = wd[15:0];
               ref_sp = ref_sp - 16'd1;
            end
            3'd4: begin
               p = ref_sp + 16'd1; era.push_back(p); e_rd = {16'h0, rm[p]}; ref_sp = p;
            end
            3'd5: begin
               ewa.push_back(ref_sp); ewd.push_back(wd[31:16]); rm[ref_sp] = wd[31:16];
               p = ref_sp - 16'd1;
               ewa.push_back(p); ewd.push_back(wd[15:0]); rm[p] = wd[15:0];
               ref_sp = ref_sp - 16'd2;
            end
            3'd6: begin
               p = ref_sp + 16'd1; era.push_back(p); e_rd[15:0] = rm[p];
               p = ref_sp + 16'd2; era.push_back(p); e_rd[31:16] = rm[p];
               ref_sp = p;
            end
            default: ;
         endcase
      end
      check("idle_before_req", bus.busy, 1'b0);
      wa_q.delete(); wd_q.delete(); ra_q.delete();
      bus.req = 1'b1; bus.op = op; bus.addr = a; bus.wdata = wd;
      @(posedge clk);
      #1 bus.req = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) check("busy_acc1", bus.busy, 1'b1);
      end while (!bus.done && n < 8);
      exp_done++;
      check($sformatf("latency_op%0d", op), n, e_lat);
      check("rdata", bus.rdata, e_rd);
      check("sp", bus.sp, ref_sp);
      check("stack_err", bus.stack_err, e_err);
      check("n_writes", wa_q.size(), ewa.size());
      check("n_reads", ra_q.size(), era.size());
      for (int i = 0; i < ewa.size() && i < wa_q.size(); i++) begin
         check("wr_addr", wa_q[i], ewa[i]);
         check("wr_data", wd_q[i], ewd[i]);
      end
      for (int i = 0; i < era.size() && i < ra_q.size(); i++)
         check("rd_addr", ra_q[i], era[i]);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_sp", bus.sp, 16'd2043);
      check("rst_wen", mem_write_enable, 1'b0);
      check("rst_ren", mem_read_enable, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      ref_sp = 16'd2043;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         dmem[i] = 16'h0;
         rm[i]   = 16'h0;
      end
      bus.req = 1'b0; bus.op = 3'd0; bus.addr = 16'h0; bus.wdata = 32'h0;
      ref_sp = 16'd2043;
      rst = 1'b1;
      #1;
      check("init_rdata", bus.rdata, 32'h0);
      check("init_stack_err", bus.stack_err, 1'b0);
      @(negedge clk);
      pulse_reset();

      issue(3'd2, 16'h0010, 32'h0000BEEF);
      issue(3'd1, 16'h0010, 32'h0);
      check("load_beef", bus.rdata, 32'h0000BEEF);

      issue(3'd3, 16'h0, 32'h00001234);
      check("sp_2042", bus.sp, 16'd2042);
      issue(3'd3, 16'h0, 32'h00005678);
      issue(3'd4, 16'h0, 32'h0);
      check("pop_5678", bus.rdata, 32'h00005678);
      issue(3'd4, 16'h0, 32'h0);
      check("pop_1234", bus.rdata, 32'h00001234);
      check("sp_2043", bus.sp, 16'd2043);

      issue(3'd5, 16'h0, 32'hAAAA5555);
      check("sp_2041", bus.sp, 16'd2041);
      issue(3'd6, 16'h0, 32'h0);
      check("pop2_val", bus.rdata, 32'hAAAA5555);
      issue(3'd0, 16'h0, 32'h0);
      issue(3'd7, 16'h0, 32'h0);

      // Abandon a PUSH2 while in its second access cycle.
      rm[ref_sp] = 16'hC0DE;
      wa_q.delete(); wd_q.delete(); ra_q.delete();
      bus.req = 1'b1; bus.op = 3'd5; bus.wdata = 32'hC0DE7777;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(posedge clk);
      #1 pulse_reset();
      repeat (3) @(negedge clk);
      check("abort_writes", wa_q.size(), 1);
      check("abort_no_done", done_cnt, exp_done);
      check("abort_mem2042", dmem[2042], rm[2042]);
      check("abort_sp", bus.sp, 16'd2043);

      issue(3'd4, 16'h0, 32'h0);
      @(negedge clk);
      pulse_reset();

      for (int k = 0; k < 250; k++)
         issue(3'($urandom_range(0, 7)), 16'($urandom_range(0, 63)), $urandom);
      issue(3'd1, 16'($urandom_range(0, 63)), 32'h0);

      @(negedge clk);
      check("dual_enable_seen", both_seen, 1'b0);
      check("done_pulses", done_cnt, exp_done);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller for the data memory. It turns memory-stage requests (load, store, push, pop, and two-word push/pop used to save and restore a 32-bit PC) into single-word memory cycles.
- Owns the stack pointer and sequences multi-word accesses.
- Drives the data memory's read/write enables, addresses and write data, and registers the returned read data.
- Sits between the execute/memory pipeline stage and the data memory.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory word width.
- SP_INIT, 2043, stack pointer reset value; the stack top is the highest usable word.
- STACK_FLOOR, 1024, lowest legal stack address. Used only when STACK_BOUNDS_CHECK_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request valid.
- op  in  3  operation: 0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 PUSH2, 6 POP2, 7 reserved.
- addr  in  16  LOAD/STORE address.
- wdata  in  32  store/push data; [15:0] for single-word ops, full 32 bits for PUSH2.
- busy  out  1  controller not in IDLE; req ignored while high.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  load/pop result; single-word results zero-extended.
- sp  out  16  current stack pointer.
- stack_err  out  1  bounds violation flag, valid with done.
- mem_read_enable  out  1  to data memory.
- mem_write_enable  out  1  to data memory.
- mem_read_addr  out  16  to data memory.
- mem_write_addr  out  16  to data memory.
- mem_write_data  out  16  to data memory.
- mem_read_data  in  16  from data memory; combinational read.

Behaviour:
- Reset (async, any state):
  - state=IDLE, sp=SP_INIT, rdata=0, done=0, stack_err=0, busy=0.
  - All mem_* outputs 0.
  - Any in-flight operation is abandoned with no further memory enables.
- FSM states: IDLE, ACC1, ACC2.
  - IDLE: req=1 at a rising edge latches op, addr and wdata → ACC1.
  - ACC1: single-word op → IDLE. PUSH2/POP2 → ACC2.
  - ACC2 → IDLE.
- Memory drive:
  - mem_* are decoded combinationally from state and latched op.
  - Enables are asserted only in ACC1/ACC2, and at most one enable per cycle.
- Read capture: read data is captured at the edge that ends the access cycle.
- Completion: at the edge leaving the last access state, done<=1 for one cycle and rdata is updated.
- Latency: req accepted at edge N → done high during cycle N+2 for single-word ops, N+3 for two-word ops.
- Back-to-back requests: req may be accepted in the same IDLE cycle that done is high.
- busy is high exactly in ACC1/ACC2.
- Stack is full-descending; sp points to the next free word.
  - PUSH: write mem[sp]=wdata[15:0]; sp-=1.
  - POP: read mem[sp+1]; sp+=1.
  - PUSH2: ACC1 writes mem[sp]=wdata[31:16]; ACC2 writes mem[sp-1]=wdata[15:0]; sp-=2 at completion.
  - POP2: ACC1 reads mem[sp+1] into low half; ACC2 reads mem[sp+2] into high half; sp+=2 at completion.
  - sp updates only at the completion edge.
- LOAD/STORE: single cycle at addr; sp unchanged.
- NOP/reserved (op 0/7): accepted, no enables, done after single-word latency, rdata=0.
- Arithmetic: sp arithmetic is modulo 2^16.

Optional Feature:
- Macro STACK_BOUNDS_CHECK_EN.
- Defined:
  - PUSH/PUSH2 require sp-(n-1) >= STACK_FLOOR.
  - POP/POP2 require sp+n <= SP_INIT (n = word count).
  - On violation: no memory enables, sp unchanged, rdata=0, done with stack_err=1 at normal latency.
- Undefined: stack_err tied 0; sp wraps silently.

Test Plan:
- Reset: pulse rst mid-run → sp=2043, busy=0, done=0, both mem enables 0 immediately, without waiting for a clock edge.
- STORE addr=0x0010, wdata=0x0000BEEF, then LOAD 0x0010 → one write cycle addr 0x0010 data 0xBEEF; done 2 cycles after each accept; load rdata=0x0000BEEF.
- PUSH 0x1234, PUSH 0x5678, POP, POP:
  - sp goes 2043→2042→2041→2042→2043.
  - POP results: rdata=0x5678 then 0x1234.
- PUSH2 0xAAAA5555 then POP2:
  - Writes mem[2043]=0xAAAA and mem[2042]=0x5555.
  - sp=2041 after PUSH2.
  - POP2 rdata=0xAAAA5555, done 3 cycles after accept, sp=2043.
- rst asserted during ACC2 of PUSH2 → second write never issued, done stays 0, sp=2043.
- POP straight after reset:
  - With STACK_BOUNDS_CHECK_EN: stack_err=1, no read enable, sp=2043.
  - Without it: read addr 2044, sp=2044.
